sf_param_bank: RTL and testbench
================================

# sf_param_bank

Double-buffered constant bank for the digaree `sf_user` engine, successor to the flat parallel regbank parameter wrapper. The host writes a shadow page word by word. Committed values are copied atomically into an active page that drives the engine's `param_in` bus, so a computation frame never sees a half-updated constant set. Commit is either immediate or deferred to the next frame trigger, and both pages can be read back.

## Interface
- `pw`, 18, width of one constant word
- `consts_len`, 4, number of constant words (1..2**const_aw)
- `const_aw`, 2, address width
- `defer`, 1, 1: commit waits for next honoured trigger; 0: commit applies immediately

Ports:
- `sf_clk`  in  1  single clock for everything
- `rst_n`  in  1  reset, synchronous, active-low
- `ce`  in  1  clock enable for trigger handling only; writes, commit requests and readback ignore it
- `trigger`  in  1  frame start, same pulse fed to `sf_user`
- `h_write`  in  1  shadow write strobe
- `h_addr`  in  const_aw  shadow write address
- `h_data`  in  pw  shadow write data
- `commit`  in  1  commit request pulse
- `h_raddr`  in  const_aw  readback address
- `h_rsel`  in  1  readback page: 0 shadow, 1 active
- `h_rdata`  out  pw  readback data
- `param_out`  out  pw*consts_len  active page; word r at bits [(r+1)*pw-1 : r*pw]
- `param_update`  out  1  one-cycle pulse, coincident with the first cycle of new `param_out`
- `pending`  out  1  commit requested, not yet applied
- `commit_cnt`  out  8  count of applied commits, wraps 255→0

## Operation
- Writes with `h_addr >= consts_len` are discarded.
- Commit event:
  - `defer=0`: any cycle with `commit=1`.
  - `defer=1`: any cycle with (`pending=1` or `commit=1`) and `trigger=1` and `ce=1`.
- On a commit event, active ← next-shadow. Next-shadow is the shadow contents including any same-cycle `h_write`, so write-first forwarding is mandatory.
- State machine, `defer=1`:
  - IDLE: `commit` with no honoured trigger → PENDING. `commit` with an honoured trigger in the same cycle → commit event, stay IDLE.
  - PENDING: honoured trigger → commit event, then IDLE. Further `commit` pulses are absorbed with no count increase. Writes keep landing in the shadow page and are included in the eventual commit.
- In `defer=0`, `pending` is constant 0.
- `trigger` without `ce`, or `trigger` in IDLE with no `commit`, has no effect on either page.
- `commit_cnt` increments once per commit event.
- Readback:
  - `h_rdata` is registered with 1-cycle latency and returns the page state as of the previous edge, so a same-cycle write is not forwarded.
  - `h_raddr >= consts_len` returns 0.
- Reset (`rst_n=0` at an edge): both pages → 0; state → IDLE, which cancels any pending commit; `commit_cnt` → 0.

## Timing
- Reset values: `param_out`=0, `param_update`=0, `pending`=0, `commit_cnt`=0, `h_rdata`=0.
- Commit event at edge N:
  - `param_out`, `commit_cnt` and the deasserted `pending` are visible after edge N.
  - `param_update` is high for exactly the cycle between edges N and N+1.
- `pending` rises on the edge that samples `commit` with no commit event.
- `param_out` changes only on commit events or reset, never otherwise.
- Back-to-back commits in `defer=0` produce back-to-back `param_update` pulses, and `commit_cnt` steps by one each cycle.
- No combinational path from any input to any output.

## Test plan
- Basic load, `defer=1`:
  - Stimulus: write words 0..3 = 100, −200, 131071, −131072; pulse `commit`; trigger 5 cycles later with `ce=1`.
  - Required: `pending` is high for those 5 cycles; `param_out` stays 0 until the trigger edge, then holds all four values; one `param_update` pulse; `commit_cnt`=1.
- Deferred with write-during-pending:
  - Stimulus: commit with word 1 = 7; write word 1 = 9 while pending; then trigger with `ce=0`; then trigger with `ce=1`.
  - Required: the `ce=0` trigger is ignored; after the `ce=1` trigger, active word 1 = 9.
- Same-cycle collisions, `defer=0`:
  - Stimulus: `h_write` (addr 2, data 55) and `commit` in the same cycle.
  - Required: active word 2 = 55 after that edge.
  - Stimulus (`defer=1`): `commit` and honoured trigger in the same cycle.
  - Required: immediate apply; `pending` never rises.
- Readback:
  - Stimulus: read shadow and active pages after a write but before its commit.
  - Required: shadow returns the new value and active the old, each one cycle after the address is presented.
  - Stimulus: read `h_raddr`=3 with `consts_len`=3.
  - Required: returns 0.
- Reset mid-pending:
  - Stimulus: assert `rst_n=0` for one cycle while PENDING; then trigger.
  - Required: all outputs return to 0; the following trigger causes no commit.
- Counter wrap:
  - Stimulus: 256 immediate commits.
  - Required: `commit_cnt` returns to 0; 256 `param_update` pulses.

Source files
------------

// File: rtl/sf_param_bank.sv
// Double-buffered constant bank: host fills a shadow page, commits copy it
// atomically into the active page driving the engine's parameter bus.
module sf_param_bank #(
  parameter int pw         = 18,
  parameter int consts_len = 4,
  parameter int const_aw   = 2,
  parameter bit defer      = 1'b1
) (
  input  logic                       sf_clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       trigger,
  input  logic                       h_write,
  input  logic [const_aw-1:0]        h_addr,
  input  logic [pw-1:0]              h_data,
  input  logic                       commit,
  input  logic [const_aw-1:0]        h_raddr,
  input  logic                       h_rsel,
  output logic [pw-1:0]              h_rdata,
  output logic [pw*consts_len-1:0]   param_out,
  output logic                       param_update,
  output logic                       pending,
  output logic [7:0]                 commit_cnt
);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t                        state_reg, state_next;
  logic [consts_len-1:0][pw-1:0] shadow_reg, shadow_next, active_reg;
  logic [pw-1:0]                 h_rdata_reg, h_rdata_next;
  logic                          param_update_reg;
  logic [7:0]                    commit_cnt_reg;
  logic                          commit_event;
  logic                          trig_ok;

  assign trig_ok = trigger & ce;

  // Write-first view of the shadow page; out-of-range addresses match no word.
  generate
    for (genvar gi = 0; gi < consts_len; gi++) begin : g_word
      localparam logic [const_aw-1:0] WORD_ADDR = const_aw'(gi);
      assign shadow_next[gi] = (h_write && h_addr == WORD_ADDR) ? h_data : shadow_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    commit_event = 1'b0;
    if (defer) begin
      case (state_reg)
        ST_IDLE: begin
          if (commit) begin
            if (trig_ok) commit_event = 1'b1;
            else         state_next   = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (trig_ok) begin
            commit_event = 1'b1;
            state_next   = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else begin
      commit_event = commit;
      state_next   = ST_IDLE;
    end
  end

  // Readback sees the pages as registered before this edge, no forwarding.
  always_comb begin
    h_rdata_next = '0;
    for (int r = 0; r < consts_len; r++) begin
      if (h_raddr == const_aw'(r)) h_rdata_next = h_rsel ? active_reg[r] : shadow_reg[r];
    end
  end

  always_ff @(posedge sf_clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      shadow_reg       <= '0;
      active_reg       <= '0;
      h_rdata_reg      <= '0;
      param_update_reg <= 1'b0;
      commit_cnt_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      shadow_reg       <= shadow_next;
      h_rdata_reg      <= h_rdata_next;
      param_update_reg <= commit_event;
      if (commit_event) begin
        active_reg     <= shadow_next;
        commit_cnt_reg <= commit_cnt_reg + 8'd1;
      end
    end
  end

  assign param_out    = active_reg;
  assign param_update = param_update_reg;
  assign pending      = (state_reg == ST_PENDING);
  assign commit_cnt   = commit_cnt_reg;
  assign h_rdata      = h_rdata_reg;

endmodule

// File: tb/tb_sf_param_bank.sv
// Bench for sf_param_bank: a deferred 4-word bank and an immediate 3-word bank
// share one stimulus stream and are checked each cycle against a page model.
module tb_sf_param_bank;

  logic sf_clk = 1'b0;
  always #5 sf_clk = ~sf_clk;

  logic        rst_n, ce, trigger, h_write, commit, h_rsel;
  logic [1:0]  h_addr, h_raddr;
  logic [17:0] h_data;
  logic [17:0] rd_a, rd_b;
  logic [71:0] po_a;
  logic [53:0] po_b;
  logic        upd_a, upd_b, pend_a, pend_b;
  logic [7:0]  cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  sf_param_bank #(.pw(18), .consts_len(4), .const_aw(2), .defer(1'b1)) dut_a (
    .sf_clk(sf_clk), .rst_n(rst_n), .ce(ce), .trigger(trigger), .h_write(h_write),
    .h_addr(h_addr), .h_data(h_data), .commit(commit), .h_raddr(h_raddr), .h_rsel(h_rsel),
    .h_rdata(rd_a), .param_out(po_a), .param_update(upd_a), .pending(pend_a), .commit_cnt(cnt_a)
  );

  sf_param_bank #(.pw(18), .consts_len(3), .const_aw(2), .defer(1'b0)) dut_b (
    .sf_clk(sf_clk), .rst_n(rst_n), .ce(ce), .trigger(trigger), .h_write(h_write),
    .h_addr(h_addr), .h_data(h_data), .commit(commit), .h_raddr(h_raddr), .h_rsel(h_rsel),
    .h_rdata(rd_b), .param_out(po_b), .param_update(upd_b), .pending(pend_b), .commit_cnt(cnt_b)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Page model: index 0 is the deferred 4-word bank, index 1 the immediate 3-word bank.
  int          m_len[2] = '{4, 3};
  bit          m_def[2] = '{1'b1, 1'b0};
  logic [17:0] m_sh[2][4];
  logic [17:0] m_act[2][4];
  logic [17:0] m_rd[2];
  bit          m_pend[2];
  bit          m_upd[2];
  int          m_cnt[2];

  always @(posedge sf_clk) begin
    bit evt, hon;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          m_sh[d][k]  = '0;
          m_act[d][k] = '0;
        end
        m_rd[d] = '0; m_pend[d] = 1'b0; m_upd[d] = 1'b0; m_cnt[d] = 0;
      end else begin
        if (int'(h_raddr) < m_len[d]) m_rd[d] = h_rsel ? m_act[d][h_raddr] : m_sh[d][h_raddr];
        else                          m_rd[d] = '0;
        if (h_write && int'(h_addr) < m_len[d]) m_sh[d][h_addr] = h_data;
        hon = trigger && ce;
        if (m_def[d]) begin
          evt       = hon && (m_pend[d] || commit);
          m_pend[d] = !evt && (m_pend[d] || commit);
        end else begin
          evt       = commit;
          m_pend[d] = 1'b0;
        end
        if (evt) begin
          for (int k = 0; k < 4; k++) m_act[d][k] = m_sh[d][k];
          m_cnt[d] = (m_cnt[d] + 1) % 256;
        end
        m_upd[d] = evt;
      end
    end
  end

  always @(negedge sf_clk) begin
    if (check_en) begin
      for (int k = 0; k < 4; k++) check("po_a", k, 32'(po_a[k*18 +: 18]), 32'(m_act[0][k]));
      for (int k = 0; k < 3; k++) check("po_b", k, 32'(po_b[k*18 +: 18]), 32'(m_act[1][k]));
      check("upd_a", 0, 32'(upd_a), 32'(m_upd[0]));
      check("upd_b", 0, 32'(upd_b), 32'(m_upd[1]));
      check("pend_a", 0, 32'(pend_a), 32'(m_pend[0]));
      check("pend_b", 0, 32'(pend_b), 32'(m_pend[1]));
      check("cnt_a", 0, 32'(cnt_a), 32'(m_cnt[0]));
      check("cnt_b", 0, 32'(cnt_b), 32'(m_cnt[1]));
      check("rd_a", 0, 32'(rd_a), 32'(m_rd[0]));
      check("rd_b", 0, 32'(rd_b), 32'(m_rd[1]));
    end
  end

  task automatic tick;
    @(posedge sf_clk);
    @(negedge sf_clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [17:0] v);
    h_write = 1'b1; h_addr = a; h_data = v;
    tick();
    h_write = 1'b0;
  endtask

  int pc, ub;

  initial begin
    rst_n = 1'b0; ce = 1'b0; trigger = 1'b0; h_write = 1'b0; commit = 1'b0;
    h_addr = '0; h_raddr = '0; h_data = '0; h_rsel = 1'b0;
    tick();
    check_en = 1'b1;
    check("lit_rst_po", 0, 32'(po_a[31:0]), 32'd0);
    check("lit_rst_cnt", 0, 32'(cnt_a), 32'd0);
    tick();
    rst_n = 1'b1;

    // Basic deferred load
    wr(2'd0, 18'd100); wr(2'd1, 18'h3FF38); wr(2'd2, 18'h1FFFF); wr(2'd3, 18'h20000);
    commit = 1'b1; tick(); commit = 1'b0;
    pc = 0;
    for (int i = 0; i < 5; i++) begin
      pc += int'(pend_a);
      check("lit_hold_po", i, 32'(po_a[17:0]), 32'd0);
      if (i < 4) tick();
    end
    check("lit_pend_cycles", 0, 32'(pc), 32'd5);
    trigger = 1'b1; ce = 1'b1; tick(); trigger = 1'b0; ce = 1'b0;
    check("lit_load_w0", 0, 32'(po_a[17:0]), 32'd100);
    check("lit_load_w1", 0, 32'(po_a[35:18]), 32'h3FF38);
    check("lit_load_w2", 0, 32'(po_a[53:36]), 32'h1FFFF);
    check("lit_load_w3", 0, 32'(po_a[71:54]), 32'h20000);
    check("lit_load_upd", 0, 32'(upd_a), 32'd1);
    check("lit_load_cnt", 0, 32'(cnt_a), 32'd1);
    tick();
    check("lit_upd_width", 0, 32'(upd_a), 32'd0);

    // Write during pending, ignored trigger without ce
    wr(2'd1, 18'd7);
    commit = 1'b1; tick(); commit = 1'b0;
    wr(2'd1, 18'd9);
    trigger = 1'b1; ce = 1'b0; tick();
    check("lit_ce0_pend", 0, 32'(pend_a), 32'd1);
    check("lit_ce0_w1", 0, 32'(po_a[35:18]), 32'h3FF38);
    ce = 1'b1; tick(); trigger = 1'b0; ce = 1'b0;
    check("lit_ce1_w1", 0, 32'(po_a[35:18]), 32'd9);
    check("lit_ce1_cnt", 0, 32'(cnt_a), 32'd2);

    // Same-cycle write and commit, then same-cycle commit and trigger
    h_write = 1'b1; h_addr = 2'd2; h_data = 18'd55; commit = 1'b1;
    tick(); h_write = 1'b0; commit = 1'b0;
    check("lit_fwd_b_w2", 0, 32'(po_b[53:36]), 32'd55);
    trigger = 1'b1; ce = 1'b1; tick();
    commit = 1'b1; tick(); commit = 1'b0; trigger = 1'b0; ce = 1'b0;
    check("lit_same_pend", 0, 32'(pend_a), 32'd0);
    check("lit_same_upd", 0, 32'(upd_a), 32'd1);
    tick();
    check("lit_same_pend2", 0, 32'(pend_a), 32'd0);

    // Readback of shadow vs active, and out-of-range address
    wr(2'd0, 18'd1234);
    h_raddr = 2'd0; h_rsel = 1'b0; tick();
    check("lit_rb_shadow", 0, 32'(rd_a), 32'd1234);
    h_rsel = 1'b1; tick();
    check("lit_rb_active", 0, 32'(rd_a), 32'd100);
    wr(2'd3, 18'd777);
    h_raddr = 2'd3; h_rsel = 1'b0; tick();
    check("lit_rb_a3", 0, 32'(rd_a), 32'd777);
    check("lit_rb_b3", 0, 32'(rd_b), 32'd0);
    h_raddr = 2'd0;

    // Reset while pending cancels the commit
    commit = 1'b1; tick(); commit = 1'b0;
    check("lit_pre_rst_pend", 0, 32'(pend_a), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("lit_rst2_po", 0, 32'(po_a[31:0]), 32'd0);
    check("lit_rst2_pend", 0, 32'(pend_a), 32'd0);
    check("lit_rst2_cnt", 0, 32'(cnt_a), 32'd0);
    trigger = 1'b1; ce = 1'b1; tick(); trigger = 1'b0; ce = 1'b0;
    check("lit_rst2_trig_upd", 0, 32'(upd_a), 32'd0);
    check("lit_rst2_trig_cnt", 0, 32'(cnt_a), 32'd0);

    // 256 back-to-back immediate commits wrap the counter
    ub = 0;
    commit = 1'b1;
    for (int i = 0; i < 256; i++) begin
      h_write = 1'b1; h_addr = 2'(i % 3); h_data = 18'(i * 37);
      tick();
      ub += int'(upd_b);
      if (i == 254) check("lit_wrap_255", 0, 32'(cnt_b), 32'd255);
    end
    commit = 1'b0; h_write = 1'b0;
    check("lit_wrap_pulses", 0, 32'(ub), 32'd256);
    check("lit_wrap_cnt", 0, 32'(cnt_b), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
